// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_ctrl
// Brief    : Program counter and fetch sequencer. Drives the branch-target
//            table index, steers the instruction address from the returned
//            target, handles the Start/Done program handshake and counts
//            cycles spent running.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl #(
  parameter int PW     = 8,
  parameter int START0 = 0,
  parameter int START1 = 0,
  parameter int START2 = 4,
  parameter int CW     = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [1:0]    ProgSel,
  input  logic          Halt,
  input  logic          Stall,
  input  logic          BranchEn,
  input  logic          BranchCond,
  input  logic [3:0]    LutIdx,
  output logic [3:0]    LutAddr,
  input  logic [PW-1:0] LutTarget,
  output logic [PW-1:0] ProgCtr,
  output logic          Running,
  output logic          Done,
  output logic [CW-1:0] CycleCnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_pc;
  logic [PW-1:0] w_pc_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [PW-1:0] w_start_pc;
  logic [CW-1:0] w_cnt_inc;
  logic          w_taken;

  // The branch table is a pure lookup, so the index is passed straight through.
  assign LutAddr  = LutIdx;
  assign ProgCtr  = r_pc;
  assign CycleCnt = r_cnt;
  assign Running  = (r_state == S_RUN);
  assign Done     = (r_state == S_HALTED);

  assign w_taken   = BranchEn & BranchCond;
  // Counter sticks at all-ones instead of wrapping.
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CW'(1);

  // Start address selection; select value 3 reuses program 1's entry point.
  always_comb begin
    w_start_pc = PW'(START0);
    case (ProgSel)
      2'd1:    w_start_pc = PW'(START1);
      2'd2:    w_start_pc = PW'(START2);
      default: w_start_pc = PW'(START0);
    endcase
  end

  // Next-state, next-PC and next-count; in RUN: stall > halt > branch > increment.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_RUN: begin
        w_cnt_nxt = w_cnt_inc;
        if (Stall) begin
          w_pc_nxt = r_pc;
        end else if (Halt) begin
          w_state_nxt = S_HALTED;
        end else if (w_taken) begin
          w_pc_nxt = LutTarget;
        end else begin
          w_pc_nxt = r_pc + PW'(1);
        end
      end
      default: begin
        // IDLE and HALTED both wait for Start and otherwise hold everything.
        if (Start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = w_start_pc;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  // State, PC and cycle-count registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_ctrl
// Brief    : Self-checking bench for pc_fetch_ctrl: a behavioural model is
//            compared every cycle, and directed scenarios pin literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, Start, Halt, Stall, BranchEn, BranchCond;
  logic [1:0] ProgSel;
  logic [3:0] LutIdx, LutAddr;
  logic [7:0] LutTarget, ProgCtr;
  logic       Running, Done;
  logic [15:0] CycleCnt;

  int n_cmp = 0;
  int n_err = 0;

  pc_fetch_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel),
    .Halt(Halt), .Stall(Stall), .BranchEn(BranchEn), .BranchCond(BranchCond),
    .LutIdx(LutIdx), .LutAddr(LutAddr), .LutTarget(LutTarget),
    .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .CycleCnt(CycleCnt)
  );

  always #5 Clk = ~Clk;

  // Behavioural model: mode 0 idle, 1 running, 2 halted.
  int m_mode  = 0;
  int m_pc    = 0;
  int m_cnt   = 0;
  bit m_valid = 1'b0;

  function automatic int start_of(input int sel);
    return (sel == 2) ? 4 : 0;
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      m_mode = 0; m_pc = 0; m_cnt = 0; m_valid = 1'b1;
    end else if (m_mode != 1) begin
      if (Start) begin
        m_mode = 1; m_pc = start_of(int'(ProgSel)); m_cnt = 0;
      end
    end else begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (Stall) begin
        // PC held, still running
      end else if (Halt) begin
        m_mode = 2;
      end else if (BranchEn && BranchCond) begin
        m_pc = int'(LutTarget);
      end else begin
        m_pc = (m_pc + 1) % 256;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (m_valid) begin
      chk("m_pc",      32'(ProgCtr),  32'(m_pc));
      chk("m_cnt",     32'(CycleCnt), 32'(m_cnt));
      chk("m_running", 32'(Running),  32'(m_mode == 1));
      chk("m_done",    32'(Done),     32'(m_mode == 2));
      chk("m_lutaddr", 32'(LutAddr),  32'(LutIdx));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic idle_in();
    Reset = 0; Start = 0; ProgSel = 0; Halt = 0; Stall = 0;
    BranchEn = 0; BranchCond = 0; LutIdx = 0; LutTarget = 0;
  endtask

  task automatic branch(input logic cond, input logic [3:0] idx, input logic [7:0] tgt);
    idle_in(); BranchEn = 1; BranchCond = cond; LutIdx = idx; LutTarget = tgt;
  endtask

  initial begin
    idle_in();
    Reset = 1; Start = 1;
    tick(); tick();
    idle_in();
    chk("rst_pc", 32'(ProgCtr), 0);
    chk("rst_run", 32'(Running), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_cnt", 32'(CycleCnt), 0);

    // Start program 3
    idle_in(); Start = 1; ProgSel = 2; tick();
    chk("start2_pc", 32'(ProgCtr), 4);
    chk("start2_run", 32'(Running), 1);
    chk("start2_cnt", 32'(CycleCnt), 0);
    idle_in(); Halt = 1; tick();
    chk("halt4_pc", 32'(ProgCtr), 4);
    chk("halt4_cnt", 32'(CycleCnt), 1);

    // Restart from HALTED at 0, three sequential fetches then halt
    idle_in(); Start = 1; ProgSel = 0; tick();
    chk("start0_pc", 32'(ProgCtr), 0);
    idle_in();
    repeat (3) tick();
    chk("seq_pc", 32'(ProgCtr), 3);
    Halt = 1; tick();
    chk("halt_pc", 32'(ProgCtr), 3);
    chk("halt_done", 32'(Done), 1);
    chk("halt_cnt", 32'(CycleCnt), 4);
    idle_in(); Halt = 1; BranchEn = 1; BranchCond = 1; LutTarget = 8'd99;
    repeat (2) tick();
    chk("halted_hold_pc", 32'(ProgCtr), 3);
    chk("halted_hold_cnt", 32'(CycleCnt), 4);

    // Taken / not-taken branch from PC 10
    idle_in(); Start = 1; ProgSel = 3; tick();
    idle_in();
    repeat (10) tick();
    chk("pc10", 32'(ProgCtr), 10);
    branch(1'b1, 4'd2, 8'd228);
    #1;
    chk("lutaddr_comb", 32'(LutAddr), 2);
    tick();
    chk("taken_pc", 32'(ProgCtr), 228);
    branch(1'b1, 4'd5, 8'd10); tick();
    branch(1'b0, 4'd2, 8'd228); tick();
    chk("nottaken_pc", 32'(ProgCtr), 11);

    // Wrap 255 -> 0
    branch(1'b1, 4'd7, 8'd250); tick();
    idle_in();
    repeat (5) tick();
    chk("pc255", 32'(ProgCtr), 255);
    tick();
    chk("wrap_pc", 32'(ProgCtr), 0);
    tick();

    // Halt together with taken branch: halt wins
    branch(1'b1, 4'd1, 8'd208); Halt = 1; tick();
    chk("haltbr_pc", 32'(ProgCtr), 1);
    chk("haltbr_done", 32'(Done), 1);

    // Stall with halt: stall wins
    idle_in(); Start = 1; ProgSel = 1; tick();
    idle_in(); Stall = 1; Halt = 1; tick();
    chk("stallhalt_pc", 32'(ProgCtr), 0);
    chk("stallhalt_run", 32'(Running), 1);
    chk("stallhalt_cnt", 32'(CycleCnt), 1);
    idle_in(); Stall = 1; tick();
    branch(1'b1, 4'd3, 8'd50); tick();
    chk("pc50", 32'(ProgCtr), 50);

    // Reset mid-run with Start high; Start is not remembered
    idle_in(); Reset = 1; Start = 1; ProgSel = 2; tick();
    chk("midrst_pc", 32'(ProgCtr), 0);
    chk("midrst_cnt", 32'(CycleCnt), 0);
    chk("midrst_run", 32'(Running), 0);
    idle_in(); tick();
    chk("norelatch_run", 32'(Running), 0);

    // Spin loop to saturate the counter
    idle_in(); Start = 1; ProgSel = 2; tick();
    branch(1'b1, 4'd9, 8'd4);
    repeat (70000) tick();
    chk("sat_cnt", 32'(CycleCnt), 65535);
    chk("spin_pc", 32'(ProgCtr), 4);
    idle_in(); Halt = 1; tick();
    chk("sat_halt_cnt", 32'(CycleCnt), 65535);
    chk("sat_halt_done", 32'(Done), 1);
    idle_in(); Start = 1; ProgSel = 2; tick();
    chk("restart_pc", 32'(ProgCtr), 4);
    chk("restart_cnt", 32'(CycleCnt), 0);
    chk("restart_done", 32'(Done), 0);
    idle_in(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter and fetch-sequencing unit: the consumer end of the branch-target lookup interface. It issues a 4-bit table index for each taken branch. It takes the 8-bit absolute target back in the same cycle and steers the instruction-memory address. It also provides the Start/Done program handshake to the testbench and top level, and counts executed cycles per program run.

Parameters:
PW, 8, program-counter / instruction-address width (matches the 8-bit branch-target width)
START0, 0, start address for program 1 (ProgSel=0)
START1, 0, start address for program 2 (ProgSel=1)
START2, 4, start address for program 3 (ProgSel=2)
CW, 16, cycle-counter width

Ports:
Clk  in  1  system clock, all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Start  in  1  begin a program; sampled only in IDLE or HALTED
ProgSel  in  2  program select; value 3 uses START0
Halt  in  1  from decoder: current instruction is halt
Stall  in  1  hold PC this cycle (multi-cycle memory op)
BranchEn  in  1  from decoder: current instruction is a branch
BranchCond  in  1  branch condition flag from ALU; taken = BranchEn & BranchCond
LutIdx  in  4  branch-table index field of the current instruction
LutAddr  out  4  index driven to branch-target table; combinational copy of LutIdx
LutTarget  in  PW  absolute target returned by table, same cycle (combinational)
ProgCtr  out  PW  current instruction address (registered)
Running  out  1  high in RUN state
Done  out  1  high in HALTED state; held until next Start
CycleCnt  out  CW  cycles spent in RUN during current/last run

Behaviour:
- States: IDLE, RUN, HALTED. Reset -> IDLE, ProgCtr=0, Done=0, Running=0, CycleCnt=0.
- IDLE/HALTED with Start=1: next state RUN, ProgCtr=START[ProgSel], CycleCnt=0, Done=0 on next edge.
- IDLE/HALTED with Start=0: hold all registers. Done stays 1 in HALTED.
- RUN: Start ignored. Per edge, priority: Stall > Halt > taken branch > increment.
  - Stall=1: ProgCtr holds. State unchanged. CycleCnt increments.
  - Halt=1: next state HALTED. ProgCtr holds at the halt instruction address. CycleCnt increments once more (halt cycle counted).
  - Taken branch: ProgCtr <= LutTarget. Not taken (BranchEn=1, BranchCond=0): ProgCtr <= ProgCtr+1.
  - Otherwise: ProgCtr <= ProgCtr+1, modulo 2^PW (255 -> 0 wraps, no flag).
- Simultaneous events:
  - Halt with taken branch: halt wins, PC holds.
  - Stall with Halt: stall wins, halt re-evaluated next cycle.
- Branch whose target equals ProgCtr is legal: it creates a spin loop.
- LutAddr = LutIdx at all times, including outside RUN. The table is a pure function, so no side effects.
- CycleCnt saturates at 2^CW-1. It never wraps.
- Reset asserted in any state (including mid-RUN or with Start high) forces the reset values on that edge. Start is not latched across reset.
- Latency:
  - Start to first valid ProgCtr: 1 edge.
  - Halt to Done: 1 edge.
  - Branch resolved: 1 edge, with no delay slot.

Test Plan:
- Reset, then Start=1 with ProgSel=2 for one cycle -> next edge ProgCtr=4, Running=1, Done=0, CycleCnt=0.
- RUN from 0, no branches for 3 cycles, then Halt=1 -> ProgCtr sequence 0,1,2,3, stays 3. Done=1 next edge. CycleCnt=4.
- At ProgCtr=10, BranchEn=1, BranchCond=1, LutIdx=2, LutTarget=228 -> LutAddr=2 same cycle, ProgCtr=228 next edge. Repeat with BranchCond=0 -> ProgCtr=11.
- ProgCtr=255 with no branch -> ProgCtr=0. Halt together with taken branch to 208 -> ProgCtr holds, Done=1. Stall with Halt -> PC holds, still RUN.
- Mid-RUN at ProgCtr=50, assert Reset with Start=1 -> IDLE, ProgCtr=0, CycleCnt=0. Start in HALTED -> restart at START[ProgSel], CycleCnt cleared.
- Force 70000 RUN cycles (spin branch to self) -> CycleCnt stays 65535.
